i2s_tx: RTL and testbench

Audio-sample serializer downstream of the `USB_MIDI_AUDIO_SYNTH` system. It accepts stereo PCM sample pairs from the synth voice mixer through a valid/ready handshake. It buffers one pair and drives the codec's I2S DAC pins: `bclk`, `lrclk` and `dacdat`, in Philips I2S format. It runs on the system's `i2s_clk_clk` output, which is the codec MCLK.

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_clkgen.sv | 57 +++++
 rtl/i2s_tx.sv | 149 ++++++++++++++
 tb/tb_i2s_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S DAC serializer.
package i2s_pkg;

    localparam int unsigned I2S_SLOT_W   = 32;
    localparam int unsigned I2S_SAMPLE_W = 16;
    localparam int unsigned I2S_BCLK_DIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i2s_state_e;

    // Counter width that stays legal for a modulus of 1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK divider and frame bit counter; idles cleared with bclk low while run_i is 0.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int unsigned SLOT_W   = I2S_SLOT_W,
    parameter int unsigned BCLK_DIV = I2S_BCLK_DIV,
    localparam int unsigned FRAME_W = 2 * SLOT_W,
    localparam int unsigned BIT_W   = cnt_w(FRAME_W)
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             run_i,
    output logic             bclk_o,
    output logic             fall_stb_o,
    output logic             frame_start_o,
    output logic [BIT_W-1:0] bit_cnt_o
);

    localparam int unsigned DIV_W = cnt_w(BCLK_DIV);

    logic [DIV_W-1:0] div_cnt_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic             bclk_q;
    logic             first_q;
    logic             div_end;

    assign div_end       = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    assign fall_stb_o    = run_i && div_end && bclk_q;
    // The first fall after leaving idle starts a frame without advancing bit_cnt.
    assign frame_start_o = fall_stb_o && (first_q || (bit_cnt_q == BIT_W'(FRAME_W - 1)));
    assign bclk_o        = bclk_q;
    assign bit_cnt_o     = bit_cnt_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bclk_q    <= 1'b0;
            first_q   <= 1'b1;
        end else if (!run_i) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bclk_q    <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            div_cnt_q <= div_end ? '0 : div_cnt_q + DIV_W'(1);
            if (div_end) begin
                bclk_q <= !bclk_q;
            end
            if (fall_stb_o) begin
                first_q   <= 1'b0;
                bit_cnt_q <= frame_start_o ? '0 : bit_cnt_q + BIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter: one-pair holding register, frame shift register
// and IDLE/RUN/DRAIN control around the i2s_clkgen bit-clock generator.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W = I2S_SAMPLE_W,
    parameter int unsigned SLOT_W   = I2S_SLOT_W,
    parameter int unsigned BCLK_DIV = I2S_BCLK_DIV
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                en,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                s_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                dacdat,
    output logic                underrun,
    output logic                busy
);

    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned BIT_W   = cnt_w(FRAME_W);

    i2s_state_e          state_q;
    logic                hold_full_q;
    logic [SAMPLE_W-1:0] hold_left_q;
    logic [SAMPLE_W-1:0] hold_right_q;
    logic [FRAME_W-1:0]  shift_q;
    logic                lrclk_q;
    logic                dacdat_q;
    logic                underrun_q;
    logic                busy_q;

    logic                fall_stb;
    logic                frame_start;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    bit_nxt;
    logic                frame_go;
    logic                frame_load;
    logic                stop_at_edge;
    logic                xfer;
    logic [FRAME_W-1:0]  load_vec;

    i2s_clkgen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .run_i         (state_q != IDLE),
        .bclk_o        (bclk),
        .fall_stb_o    (fall_stb),
        .frame_start_o (frame_start),
        .bit_cnt_o     (bit_cnt)
    );

    // A frame boundary starts a new frame unless DRAIN is ending with en still low.
    assign frame_go     = frame_start && ((state_q == RUN) || en);
    assign stop_at_edge = frame_start && (state_q == DRAIN) && !en;
    assign frame_load   = frame_go && hold_full_q;
    assign s_ready      = !hold_full_q || frame_load;
    assign xfer         = s_valid && s_ready;
    assign bit_nxt      = bit_cnt + BIT_W'(1);

    assign lrclk    = lrclk_q;
    assign dacdat   = dacdat_q;
    assign underrun = underrun_q;
    assign busy     = busy_q;

    // Period 0 of each slot is blank; the sample MSB lands one BCLK after lrclk moves.
    always_comb begin
        load_vec = '0;
        if (hold_full_q) begin
            load_vec[FRAME_W-2 -: SAMPLE_W] = hold_left_q;
            load_vec[SLOT_W-2  -: SAMPLE_W] = hold_right_q;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hold_full_q  <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
        end else if (xfer) begin
            hold_full_q  <= 1'b1;
            hold_left_q  <= s_left;
            hold_right_q <= s_right;
        end else if (frame_load) begin
            hold_full_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            lrclk_q    <= 1'b0;
            dacdat_q   <= 1'b0;
            shift_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (en) begin
                        state_q <= RUN;
                    end else if (frame_start) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            underrun_q <= frame_go && !hold_full_q;

            if (stop_at_edge) begin
                lrclk_q  <= 1'b0;
                dacdat_q <= 1'b0;
                shift_q  <= '0;
            end else if (frame_go) begin
                lrclk_q  <= 1'b0;
                dacdat_q <= load_vec[FRAME_W-1];
                shift_q  <= {load_vec[FRAME_W-2:0], 1'b0};
            end else if (fall_stb) begin
                lrclk_q  <= (bit_nxt >= BIT_W'(SLOT_W));
                dacdat_q <= shift_q[FRAME_W-1];
                shift_q  <= {shift_q[FRAME_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboarded bench for i2s_tx: a codec-side monitor deserializes frames on BCLK rises.
module tb_i2s_tx;

    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned SLOT_W    = 32;
    localparam int unsigned BCLK_DIV  = 2;
    localparam int unsigned FRAME_W   = 2 * SLOT_W;
    localparam int unsigned FRAME_CYC = FRAME_W * 2 * BCLK_DIV;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } pair_t;

    logic                clk_clk = 1'b0;
    logic                reset_reset_n;
    logic                en;
    logic                s_valid;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;
    logic                s_ready;
    logic                bclk;
    logic                lrclk;
    logic                dacdat;
    logic                underrun;
    logic                busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    pair_t       sb[$];

    i2s_tx #(
        .SAMPLE_W (SAMPLE_W),
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .en            (en),
        .s_valid       (s_valid),
        .s_left        (s_left),
        .s_right       (s_right),
        .s_ready       (s_ready),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .dacdat        (dacdat),
        .underrun      (underrun),
        .busy          (busy)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- monitor: behaves like the codec ----------------
    logic                bclk_prev = 1'b0;
    logic                started   = 1'b0;
    logic                cur_ur    = 1'b0;
    logic                rise, fall;
    logic [SAMPLE_W-1:0] cap_l, cap_r;
    int                  pos = 0, slot = 0;
    int                  lr_err = 0, pad_err = 0;
    int                  ur_frames = 0, ur_stray = 0;
    int unsigned         last_end = 0, prev_end = 0;
    pair_t               exp_p;

    initial begin : monitor
        forever begin
            @(negedge clk_clk);
            rise      = bclk && !bclk_prev;
            fall      = !bclk && bclk_prev;
            bclk_prev = bclk;
            if (!reset_reset_n || !busy) begin
                started = 1'b0;
                pos     = 0;
            end else begin
                if (fall && (!started || pos == 0)) begin
                    started = 1'b1;
                    cur_ur  = underrun;
                    cap_l   = '0;
                    cap_r   = '0;
                    lr_err  = 0;
                    pad_err = 0;
                end else if (underrun) begin
                    ur_stray++;
                end
                if (rise && started) begin
                    slot = pos % SLOT_W;
                    if (lrclk !== (pos >= SLOT_W)) lr_err++;
                    if (slot >= 1 && slot <= SAMPLE_W) begin
                        if (pos >= SLOT_W) cap_r[SAMPLE_W - slot] = dacdat;
                        else               cap_l[SAMPLE_W - slot] = dacdat;
                    end else if (dacdat !== 1'b0) begin
                        pad_err++;
                    end
                    pos++;
                    if (pos == FRAME_W) begin
                        exp_p = '0;
                        if (cur_ur) begin
                            ur_frames++;
                        end else begin
                            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                            if (sb.size() != 0) exp_p = sb.pop_front();
                        end
                        check("frame", {cap_l, cap_r, 16'(lr_err), 16'(pad_err)},
                              {exp_p.l, exp_p.r, 32'h0});
                        prev_end = last_end;
                        last_end = cyc;
                        pos      = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r,
                        output int unsigned t);
        int unsigned n = 0;
        @(negedge clk_clk);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        while (!s_ready && n < 4 * FRAME_CYC) begin
            @(negedge clk_clk);
            n++;
        end
        check("send_ready", 64'(s_ready), 64'd1);
        t = cyc;
        if (s_ready) sb.push_back({l, r});
        @(posedge clk_clk);
    endtask

    task automatic drop_valid();
        @(negedge clk_clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        while (busy && n < 2 * FRAME_CYC) begin
            @(negedge clk_clk);
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    int unsigned t_x[8];
    int unsigned t_tmp;
    int          ur_base, n_hi, n_low;
    int unsigned n;

    initial begin : stim
        reset_reset_n = 1'b0;
        en            = 1'b0;
        s_valid       = 1'b0;
        s_left        = '0;
        s_right       = '0;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check("rst_bclk",     64'(bclk),     64'd0);
        check("rst_lrclk",    64'(lrclk),    64'd0);
        check("rst_dacdat",   64'(dacdat),   64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_s_ready",  64'(s_ready),  64'd1);

        // Basic pair, preloaded in IDLE.
        send(16'h8001, 16'h7FFE, t_tmp);
        drop_valid();
        check("preload_ready_low", 64'(s_ready), 64'd0);
        en = 1'b1;
        @(negedge clk_clk);
        check("busy_rise", 64'(busy), 64'd1);
        check("bclk_low_at_start", 64'(bclk), 64'd0);
        n = 0;
        while (!bclk && n < 20) begin
            @(negedge clk_clk);
            n++;
        end
        check("first_bclk_delay", 64'(n), 64'(BCLK_DIV));

        // Streaming: every transfer lands in a frame_load cycle.
        ur_base = ur_frames;
        for (int i = 0; i < 8; i++) begin
            send(SAMPLE_W'(16'h1100 + i), SAMPLE_W'(16'hE200 + i), t_x[i]);
        end
        drop_valid();
        for (int i = 1; i < 8; i++) begin
            check("stream_interval", 64'(t_x[i] - t_x[i-1]), 64'(FRAME_CYC));
        end
        check("stream_no_underrun", 64'(ur_frames - ur_base), 64'd0);

        // Underrun: empty holding register gives zero frames and single-cycle pulses.
        n = 0;
        while (!underrun && n < 4 * FRAME_CYC) begin
            @(negedge clk_clk);
            n++;
        end
        check("underrun_seen", 64'(underrun), 64'd1);
        n_hi = 0;
        repeat (2 * FRAME_CYC + FRAME_CYC / 2) begin
            @(negedge clk_clk);
            if (underrun) n_hi++;
        end
        check("underrun_pulses", 64'(n_hi), 64'd2);
        send(16'hA5A5, 16'h5A5A, t_tmp);
        drop_valid();
        n_hi = 0;
        repeat (FRAME_CYC) begin
            @(negedge clk_clk);
            if (underrun) n_hi++;
        end
        check("refill_no_underrun", 64'(n_hi), 64'd0);

        // Drain then restart before the boundary: no gap.
        send(16'h0F0F, 16'hF0F0, t_tmp);
        drop_valid();
        en = 1'b0;
        repeat (64) @(negedge clk_clk);
        en = 1'b1;
        n_low = 0;
        repeat (2 * FRAME_CYC) begin
            @(negedge clk_clk);
            if (!busy) n_low++;
        end
        check("restart_busy_low", 64'(n_low), 64'd0);
        check("restart_frame_gap", 64'(last_end - prev_end), 64'(FRAME_CYC));

        // Drain to idle: the data frame completes, then everything parks low.
        send(16'h3C3C, 16'hC3C3, t_tmp);
        drop_valid();
        repeat (FRAME_CYC) @(negedge clk_clk);
        en = 1'b0;
        wait_idle("drain_idle");
        check("drain_boundary", 64'(cyc - last_end), 64'(BCLK_DIV));
        check("drain_outputs", {61'd0, bclk, lrclk, dacdat}, 64'd0);
        repeat (20) @(negedge clk_clk);
        check("idle_hold", {61'd0, bclk, lrclk, busy}, 64'd0);

        // Asynchronous reset in the right slot of a frame.
        send(16'h1234, 16'h4321, t_tmp);
        drop_valid();
        check("hold_full_ready", 64'(s_ready), 64'd0);
        en = 1'b1;
        n = 0;
        while (!(bclk && lrclk) && n < 2 * FRAME_CYC) begin
            @(negedge clk_clk);
            n++;
        end
        check("pre_reset_state", {62'd0, bclk, lrclk}, 64'd3);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("arst_outputs", {58'd0, bclk, lrclk, dacdat, underrun, busy, s_ready}, 64'd1);
        sb.delete();
        en = 1'b0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check("post_reset_ready", {62'd0, s_ready, busy}, 64'd2);

        // Recovery with extreme sample values.
        send(16'h7FFF, 16'h8000, t_tmp);
        drop_valid();
        en = 1'b1;
        repeat (FRAME_CYC + FRAME_CYC / 2 + 10) @(negedge clk_clk);
        en = 1'b0;
        wait_idle("final_idle");
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("underrun_stray", 64'(ur_stray), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
